weight_stream_mem: RTL
======================

Name: weight_stream_mem

Overview:
- Parametrised, writable successor to the fixed ANN weight ROM. Holds an INPUT_NODES x OUTPUT_NODES weight matrix of DATA_WIDTH-bit IEEE-754 words.
- Per requested input-node row, streams that row's OUTPUT_NODES weights as CHUNKS = OUTPUT_NODES/LANES beats of LANES weights, using valid/ready handshakes.
- Sits between the host loader (write port) and the fully-connected MAC array (stream consumer).

Parameters:
- DATA_WIDTH, 32, bits per weight
- INPUT_NODES, 100, rows (input neurons)
- OUTPUT_NODES, 32, weights per row (output neurons)
- LANES, 8, weights per output beat; must divide OUTPUT_NODES (elaboration error otherwise)
- ROW_W, 8, width of row address

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one chunk word this cycle
- wr_addr  in  $clog2(INPUT_NODES*CHUNKS)  chunk index = row*CHUNKS + chunk
- wr_data  in  DATA_WIDTH*LANES  lane 0 in MS slice (weight index chunk*LANES+0)
- req_valid  in  1  row request valid
- req_ready  out  1  request accepted when valid&&ready
- req_row  in  ROW_W  requested row
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH*LANES  beat; weight chunk*LANES+i at slice (LANES-1-i)*DATA_WIDTH
- out_last  out  1  final beat of row
- out_err  out  1  row out of range (data forced zero)

Behaviour:
- Storage: INPUT_NODES*CHUNKS words of DATA_WIDTH*LANES, uninitialised (loaded by host); synchronous write; synchronous read straight into out_data register.
- FSM states IDLE, STREAM; chunk counter cnt (0..CHUNKS-1); latched row/err.
- Reset (async, rst_n=0): state=IDLE, cnt=0, out_valid=0, out_last=0, out_err=0, out_data=0. Memory contents untouched.
- req_ready = (state==IDLE) || (STREAM && out_valid && out_ready && out_last). Back-to-back rows stream with no bubble.
- Request accept at edge T: out_data<=mem[req_row*CHUNKS], cnt<=0, out_valid=1 from T+1 (latency 1), state=STREAM.
- Range check: req_row >= INPUT_NODES -> out_err=1 and out_data=0 for all CHUNKS beats; the memory is not read.
- Beat k accepted (out_valid&&out_ready), k<CHUNKS-1: cnt<=k+1, out_data<=chunk k+1, out_valid stays 1.
- Last beat accepted with no new request: out_valid<=0, out_last<=0, state=IDLE. With a new request in the same cycle: load chunk 0 of the new row.
- out_ready=0: out_data, out_last and out_err hold stable (AXI-style; no change while valid&&!ready).
- out_last = (cnt==CHUNKS-1) while valid. For CHUNKS==1, every beat is last.
- Write/read same address same edge: read returns old data; write commits.
- Writes accepted in any state. wr_addr >= INPUT_NODES*CHUNKS is ignored.
- Reset mid-stream: stream aborted, no further beats. Consumer must discard the partial row.

Optional Feature:
- Macro WMEM_PARITY_EN.
- Defined: each word stores an extra even-parity bit computed on write. Adds output port par_err (1 bit, reset 0), asserted alongside a beat whose stored parity mismatches on read. Forced 0 on out_err beats.
- Not defined: no parity storage, no par_err port. Behaviour is otherwise identical.

Decomposition:
- Shared package ann_pkg: DATA_WIDTH default, FP32 type, CHUNKS computation function, lane slice helper.
- One sub-module: wmem_ram (single write port, single synchronous read port, optional parity bit), so the FPGA block RAM can be inferred and swapped independently.

Test Plan:
- Reset then idle: after rst_n release, out_valid=0, req_ready=1, out_data=0; rst_n low mid-stream drops out_valid asynchronously.
- Load and read: write chunks 4..7 of row 1 with distinct patterns (e.g. 32'h3e0b8f42 in lane 0 of chunk 4). Request row 1 with out_ready=1 -> 4 consecutive beats from T+1, out_last on beat 4, exact slice ordering.
- Backpressure: request row 0, toggle out_ready 1,0,0,1,... -> data stable while stalled, exactly 4 beats, no duplication or loss.
- Back-to-back: hold req_valid with rows 2 then 3 -> 8 contiguous beats, no idle cycle between last of row 2 and first of row 3.
- Out of range: req_row=100 and 255 -> 4 beats of zero, out_err=1 on each, out_last on 4th.
- Parity (WMEM_PARITY_EN): force-flip a stored bit in row 5 chunk 2 -> par_err=1 only on beat 3.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared ANN definitions: default word width, FP32 type, chunking and lane helpers.
package ann_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [31:0] fp32_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } wsm_state_e;

  function automatic int chunks_f(input int outputs, input int lanes);
    return outputs / lanes;
  endfunction

  // Lane 0 sits in the most-significant slice of a beat.
  function automatic int lane_lsb_f(input int lane, input int lanes, input int dw);
    return (lanes - 1 - lane) * dw;
  endfunction

endpackage

// File: rtl/wmem_ram.sv
// Simple dual-port weight RAM: one synchronous write port, one registered read port.
// Optional even-parity bit per word when WMEM_PARITY_EN is defined.
module wmem_ram #(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 400,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
`ifdef WMEM_PARITY_EN
  ,
  output logic              par_err_o
`endif
);

`ifdef WMEM_PARITY_EN
  localparam int MW = WORD_W + 1;
`else
  localparam int MW = WORD_W;
`endif

  logic [MW-1:0]     mem_q [DEPTH];
  logic [MW-1:0]     wr_word_s;
  logic [WORD_W-1:0] rd_q;

`ifdef WMEM_PARITY_EN
  logic par_err_q;
  assign wr_word_s = {^wr_data_i, wr_data_i};
  assign par_err_o = par_err_q;
`else
  assign wr_word_s = wr_data_i;
`endif

  // Storage write; addresses beyond the array are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_word_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
`ifdef WMEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else if (rd_clr_i) begin
      rd_q <= '0;
`ifdef WMEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i][WORD_W-1:0];
`ifdef WMEM_PARITY_EN
      par_err_q <= ^mem_q[rd_addr_i];
`endif
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/weight_stream_mem.sv
// Writable ANN weight store streaming one row as CHUNKS beats of LANES weights.
// Optional stored-parity checking enabled with `define WMEM_PARITY_EN.
module weight_stream_mem
  import ann_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int INPUT_NODES  = 100,
  parameter int OUTPUT_NODES = 32,
  parameter int LANES        = 8,
  parameter int ROW_W        = 8,
  localparam int CHUNKS = chunks_f(OUTPUT_NODES, LANES),
  localparam int WORD_W = DATA_WIDTH * LANES,
  localparam int DEPTH  = INPUT_NODES * CHUNKS,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ROW_W-1:0]  req_row_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_err_o
`ifdef WMEM_PARITY_EN
  ,
  output logic              par_err_o
`endif
);

  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

  if (OUTPUT_NODES % LANES != 0) begin : g_lanes_chk
    $error("LANES must divide OUTPUT_NODES");
  end

  wsm_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [ROW_W-1:0] row_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             out_err_q;

  logic             req_acc_s;
  logic             beat_acc_s;
  logic             row_oor_s;
  logic             rd_en_s;
  logic             rd_clr_s;
  logic [AW-1:0]    rd_addr_s;

  assign beat_acc_s  = out_valid_q && out_ready_i;
  assign req_ready_o = (state_q == ST_IDLE) ||
                       ((state_q == ST_STREAM) && beat_acc_s && out_last_q);
  assign req_acc_s   = req_valid_i && req_ready_o;
  assign row_oor_s   = int'(req_row_i) >= INPUT_NODES;
  assign cnt_d       = cnt_q + CW'(1);

  // Read steering: a new row loads chunk 0, an accepted non-final beat loads the next chunk.
  always_comb begin
    rd_en_s   = 1'b0;
    rd_clr_s  = 1'b0;
    rd_addr_s = '0;
    if (req_acc_s) begin
      if (row_oor_s) begin
        rd_clr_s = 1'b1;
      end else begin
        rd_en_s   = 1'b1;
        rd_addr_s = AW'(req_row_i) * AW'(CHUNKS);
      end
    end else if (beat_acc_s && !out_last_q) begin
      if (out_err_q) begin
        rd_clr_s = 1'b1;
      end else begin
        rd_en_s   = 1'b1;
        rd_addr_s = AW'(row_q) * AW'(CHUNKS) + AW'(cnt_d);
      end
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Stream FSM; all beat qualifiers are registered and hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (req_acc_s) begin
      state_q     <= ST_STREAM;
      cnt_q       <= '0;
      row_q       <= req_row_i;
      out_valid_q <= 1'b1;
      out_last_q  <= (CHUNKS == 1);
      out_err_q   <= row_oor_s;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
        end
        ST_STREAM: begin
          if (beat_acc_s && out_last_q) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
          end else if (beat_acc_s) begin
            cnt_q      <= cnt_d;
            out_last_q <= (cnt_d == LAST_CNT);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_err_q   <= 1'b0;
        end
      endcase
    end
  end

  wmem_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_s),
    .rd_clr_i  (rd_clr_s),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (out_data_o)
`ifdef WMEM_PARITY_EN
    ,
    .par_err_o (par_err_o)
`endif
  );

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_err_o   = out_err_q;

endmodule
